// File: rtl/ad_trig_capture.sv
`default_nettype none
// ============================================================================
// ad_trig_capture : level-triggered capture of 2^AW ADC samples, pre-trigger
// depth programmable. Define ADC_TRIG_HYST_EN for hysteresis-qualified edges.
// Revision 1.0
// ============================================================================
module ad_trig_capture #(
  parameter int DW   = 10,
  parameter int AW   = 10,
  parameter int HYST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_valid,
  input  logic          arm,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_rising,
  input  logic [AW-1:0] pre_len,
  input  logic          force_trig,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic [AW-1:0] trig_ptr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, cnt_q, cnt_d;
  logic [AW-1:0] pre_len_q, pre_len_d, trig_ptr_q, trig_ptr_d;
  logic [DW-1:0] level_q, level_d, prev_q, prev_d;
  logic          rising_q, rising_d, prev_vld_q, prev_vld_d;
  logic          force_pend_q, force_pend_d;
  logic          busy_q, busy_d, triggered_q, triggered_d, done_q, done_d;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem [DEPTH];

  logic          w_arm_take, w_track, w_we, w_cross, w_hyst_ok, w_hit;
  logic [AW-1:0] w_post_len, w_rd_idx;

  assign w_arm_take = arm && (state_q == S_IDLE || state_q == S_DONE);
  assign w_track    = ad_valid && (state_q == S_PRE || state_q == S_WAIT_TRIG);
  assign w_we       = ad_valid && (state_q == S_PRE || state_q == S_WAIT_TRIG ||
                                   state_q == S_POST);
  assign w_cross    = rising_q ? (prev_q < level_q && ad_data >= level_q)
                               : (prev_q > level_q && ad_data <= level_q);
  assign w_hit      = force_pend_q || (prev_vld_q && w_cross && w_hyst_ok);
  assign w_post_len = {AW{1'b1}} - pre_len_q;
  assign w_rd_idx   = trig_ptr_q - pre_len_q + rd_addr;

`ifdef ADC_TRIG_HYST_EN
  logic          hyst_arm_q, hyst_arm_d;
  logic [DW:0]   w_hi_ext;
  logic [DW-1:0] w_hi, w_lo;
  logic          w_rearm;

  // Re-arm thresholds saturate at the ends of the code range.
  assign w_hi_ext  = {1'b0, level_q} + (DW+1)'(HYST);
  assign w_hi      = w_hi_ext[DW] ? {DW{1'b1}} : w_hi_ext[DW-1:0];
  assign w_lo      = (level_q > DW'(HYST)) ? level_q - DW'(HYST) : '0;
  assign w_rearm   = rising_q ? (ad_data <= w_lo) : (ad_data >= w_hi);
  assign w_hyst_ok = hyst_arm_q;

  always_comb begin
    hyst_arm_d = hyst_arm_q;
    if (w_arm_take)   hyst_arm_d = 1'b0;
    else if (w_track) hyst_arm_d = hyst_arm_q | w_rearm;
  end

  always_ff @(posedge clk) begin
    if (rst) hyst_arm_q <= 1'b0;
    else     hyst_arm_q <= hyst_arm_d;
  end
`else
  assign w_hyst_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    pre_len_d    = pre_len_q;
    trig_ptr_d   = trig_ptr_q;
    level_d      = level_q;
    rising_d     = rising_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    force_pend_d = force_pend_q;
    busy_d       = busy_q;
    triggered_d  = triggered_q;
    done_d       = done_q;

    if (w_we) wptr_d = wptr_q + AW'(1);
    if (w_track) begin
      prev_d     = ad_data;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          level_d      = trig_level;
          rising_d     = trig_rising;
          pre_len_d    = pre_len;
          cnt_d        = '0;
          prev_vld_d   = 1'b0;
          force_pend_d = 1'b0;
          done_d       = 1'b0;
          triggered_d  = 1'b0;
          busy_d       = 1'b1;
          state_d      = (pre_len == '0) ? S_WAIT_TRIG : S_PRE;
        end
      end
      S_PRE: begin
        if (ad_valid) begin
          if (cnt_q == pre_len_q - AW'(1)) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_WAIT_TRIG: begin
        if (force_trig) force_pend_d = 1'b1;
        if (ad_valid && w_hit) begin
          trig_ptr_d   = wptr_q;
          triggered_d  = 1'b1;
          force_pend_d = 1'b0;
          cnt_d        = w_post_len;
          if (w_post_len == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (ad_valid) begin
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      trig_ptr_q   <= '0;
      level_q      <= '0;
      rising_q     <= 1'b0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      pre_len_q    <= pre_len_d;
      trig_ptr_q   <= trig_ptr_d;
      level_q      <= level_d;
      rising_q     <= rising_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      force_pend_q <= force_pend_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  // Sample RAM is never reset; only its registered read port is.
  always_ff @(posedge clk) begin
    if (w_we) mem[wptr_q] <= ad_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[w_rd_idx];
  end

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_ptr  = trig_ptr_q;
  assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_trig_capture.sv
`default_nettype none
// Bench for ad_trig_capture with AW=4: directed captures, scoreboarded reads.
module tb_ad_trig_capture;
  localparam int DW = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ad_data = '0;
  logic          ad_valid = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_rising = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic          force_trig = 1'b0;
  logic          busy, triggered, done;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  ad_trig_capture #(.DW(DW), .AW(AW), .HYST(8)) dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid), .arm(arm),
    .trig_level(trig_level), .trig_rising(trig_rising), .pre_len(pre_len),
    .force_trig(force_trig), .busy(busy), .triggered(triggered), .done(done),
    .trig_ptr(trig_ptr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int win[16];
  int seq[8] = '{99, 101, 99, 101, 99, 101, 90, 101};
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  always @(posedge clk) rd_vld <= rd_req;

  // Read monitor: one registered read result per issued request.
  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %0d, required no read result", rd_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(rd_data) !== e) begin
          failures++;
          $display("FAIL rd_data: got %0d, required %0d", rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_arm(input int lvl, input logic rise, input int pre);
    @(negedge clk);
    arm = 1'b1;
    trig_level = DW'(lvl);
    trig_rising = rise;
    pre_len = AW'(pre);
    @(negedge clk);
    arm = 1'b0;
    check("busy_after_arm", int'(busy), 1);
    check("done_cleared", int'(done), 0);
  endtask

  // Feed start + step*k every cycle until done (bounded).
  task automatic feed_ramp(input int start, input int step, input int maxn);
    for (int k = 0; k < maxn; k++) begin
      @(negedge clk);
      if (done) break;
      ad_data = DW'(start + step * k);
      ad_valid = 1'b1;
    end
    ad_valid = 1'b0;
    check("done_after_feed", int'(done), 1);
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = AW'(i);
      rd_req = 1'b1;
      exp_q.push_back(win[i]);
    end
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("rd_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_triggered", int'(triggered), 0);
    check("rst_done", int'(done), 0);
    check("rst_trig_ptr", int'(trig_ptr), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;

    // Rising trigger on ramp, pre_len 4
    do_arm(100, 1'b1, 4);
    feed_ramp(0, 10, 40);
    check("rise_triggered", int'(triggered), 1);
    check("rise_trig_ptr", int'(trig_ptr), 10);
    for (int i = 0; i < 16; i++) win[i] = 60 + 10 * i;
    read_all();

    // Falling trigger, pre_len 0
    do_arm(200, 1'b0, 0);
    feed_ramp(300, -10, 40);
    for (int i = 0; i < 16; i++) win[i] = 200 - 10 * i;
    read_all();

    // Constant input, forced trigger
    do_arm(100, 1'b1, 4);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ad_data = DW'(512);
      ad_valid = 1'b1;
    end
    @(negedge clk);
    ad_valid = 1'b0;
    force_trig = 1'b1;
    check("const_no_trig", int'(triggered), 0);
    @(negedge clk);
    force_trig = 1'b0;
    ad_valid = 1'b1;
    check("force_pending_only", int'(triggered), 0);
    @(negedge clk);
    ad_valid = 1'b0;
    check("force_trig_next", int'(triggered), 1);
    feed_ramp(512, 0, 40);
    for (int i = 0; i < 16; i++) win[i] = 512;
    read_all();

    // Sparse valid, pre_len 15 -> zero post count
    do_arm(200, 1'b1, 15);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ad_data = DW'(10 * k);
      ad_valid = 1'b1;
      @(negedge clk);
      ad_valid = 1'b0;
      if (k == 19) check("sparse_not_done", int'(done), 0);
      if (k == 20) begin
        check("sparse_done", int'(done), 1);
        check("sparse_triggered", int'(triggered), 1);
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) win[i] = 50 + 10 * i;
    read_all();

    // Reset in POST, then recapture
    do_arm(100, 1'b1, 4);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      ad_data = DW'(10 * k);
      ad_valid = 1'b1;
    end
    @(negedge clk);
    ad_valid = 1'b0;
    check("post_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_triggered", int'(triggered), 0);
    check("abort_done", int'(done), 0);
    check("abort_trig_ptr", int'(trig_ptr), 0);
    do_arm(100, 1'b1, 4);
    feed_ramp(0, 10, 40);
    check("recap_trig_ptr", int'(trig_ptr), 10);
    for (int i = 0; i < 16; i++) win[i] = 60 + 10 * i;
    read_all();

    // Chatter around the level; hysteresis delays the trigger to the dip
`ifdef ADC_TRIG_HYST_EN
    t = 7;
`else
    t = 1;
`endif
    do_arm(100, 1'b1, 0);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) break;
      if (j == t) check("chatter_not_yet", int'(triggered), 0);
      if (j == t + 1) check("chatter_trig", int'(triggered), 1);
      ad_data = (j <= t) ? DW'(seq[j]) : DW'(200 + j - t - 1);
      ad_valid = 1'b1;
    end
    ad_valid = 1'b0;
    check("chatter_done", int'(done), 1);
    win[0] = 101;
    for (int i = 1; i < 16; i++) win[i] = 199 + i;
    read_all();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
